// File: rtl/f2sdram_safe_terminator_v2.sv
// f2sdram_safe_terminator_v2: guard between a user Avalon-MM master and an HPS f2sdram
// slave port. On a synchronous reset request it finishes any in-flight write burst,
// holds an unaccepted read command until accepted, optionally drains outstanding read
// beats, and parks the port idle with a quiesced flag.
//
// Build option: define TERM_READ_DRAIN_EN to include the pending-read tracker and the
// RD_DRAIN state. Without it, WR_DRAIN and RD_HOLD finish straight into LOCK.
`timescale 1ns / 1ps

module f2sdram_safe_terminator_v2 #(
  parameter int unsigned DATA_WIDTH       = 64,
  parameter int unsigned BURSTCOUNT_WIDTH = 8,
  parameter int unsigned ADDRESS_WIDTH    = 29,
  parameter int unsigned MAX_RD_PENDING   = 64
) (
  input  logic                        clk,
  input  logic                        rst_req_sync,
  // f2sdram side
  input  logic                        waitrequest_master,
  output logic [BURSTCOUNT_WIDTH-1:0] burstcount_master,
  output logic [ADDRESS_WIDTH-1:0]    address_master,
  input  logic [DATA_WIDTH-1:0]       readdata_master,
  input  logic                        readdatavalid_master,
  output logic                        read_master,
  output logic [DATA_WIDTH-1:0]       writedata_master,
  output logic [DATA_WIDTH/8-1:0]     byteenable_master,
  output logic                        write_master,
  // user side
  output logic                        waitrequest_slave,
  input  logic [BURSTCOUNT_WIDTH-1:0] burstcount_slave,
  input  logic [ADDRESS_WIDTH-1:0]    address_slave,
  output logic [DATA_WIDTH-1:0]       readdata_slave,
  output logic                        readdatavalid_slave,
  input  logic                        read_slave,
  input  logic [DATA_WIDTH-1:0]       writedata_slave,
  input  logic [DATA_WIDTH/8-1:0]     byteenable_slave,
  input  logic                        write_slave,
  // status
  output logic                        quiesced,
  output logic                        term_busy
);

  typedef enum logic [2:0] {
    StPass    = 3'd0,
    StWrDrain = 3'd1,
    StRdHold  = 3'd2,
`ifdef TERM_READ_DRAIN_EN
    StRdDrain = 3'd3,
`endif
    StLock    = 3'd4
  } state_e;

  // Power-up values come from declaration initialisers: the reset request must not
  // clear anything that has to observe the transaction in flight when it arrives.
  state_e state_q     = StPass;
  state_e state_d;
  logic   init_seen_q = 1'b0;
  logic   quiesced_q  = 1'b0;
  logic   term_busy_q = 1'b0;

  // Write burst tracker
  logic                        wr_active_q = 1'b0;
  logic                        wr_active_d;
  logic [BURSTCOUNT_WIDTH-1:0] wr_len_q    = '0;
  logic [BURSTCOUNT_WIDTH-1:0] wr_len_d;
  logic [BURSTCOUNT_WIDTH-1:0] wr_cnt_q    = '0;
  logic [BURSTCOUNT_WIDTH-1:0] wr_cnt_d;
  logic [BURSTCOUNT_WIDTH-1:0] wr_cnt_inc;
  logic [ADDRESS_WIDTH-1:0]    wr_addr_q   = '0;
  logic [ADDRESS_WIDTH-1:0]    wr_addr_d;
  logic                        wr_start;
  logic                        wr_beat;

  // Held read command
  logic [BURSTCOUNT_WIDTH-1:0] rd_len_q  = '0;
  logic [ADDRESS_WIDTH-1:0]    rd_addr_q = '0;
  logic                        rd_cmd_acc;

  // Where a finished drain goes next
  state_e drain_target;

`ifdef TERM_READ_DRAIN_EN
  localparam int unsigned PEND_W = $clog2(MAX_RD_PENDING + 1);
  localparam int unsigned SUM_W  = PEND_W + BURSTCOUNT_WIDTH + 1;

  logic [PEND_W-1:0] pend_q   = '0;
  logic [PEND_W-1:0] pend_d;
  logic              rd_ovf_q = 1'b0;
  logic              rd_ovf_d;
  logic [SUM_W-1:0]  pend_add;
  logic [SUM_W-1:0]  pend_sum;
  logic              pend_dec;
`endif

  // Master/user bus steering: transparent in PASS, terminator-driven elsewhere
  always_comb begin
    writedata_master    = writedata_slave;
    readdata_slave      = readdata_master;
    burstcount_master   = '0;
    address_master      = '0;
    read_master         = 1'b0;
    write_master        = 1'b0;
    byteenable_master   = '0;
    waitrequest_slave   = 1'b1;
    readdatavalid_slave = 1'b0;
    unique case (state_q)
      StPass: begin
        burstcount_master   = burstcount_slave;
        address_master      = address_slave;
        read_master         = read_slave;
        write_master        = write_slave;
        byteenable_master   = byteenable_slave;
        waitrequest_slave   = waitrequest_master;
        readdatavalid_slave = readdatavalid_master;
      end
      StWrDrain: begin
        // Remaining beats are dummies: all byte lanes disabled
        write_master      = 1'b1;
        burstcount_master = wr_len_q;
        address_master    = wr_addr_q;
      end
      StRdHold: begin
        read_master       = 1'b1;
        burstcount_master = rd_len_q;
        address_master    = rd_addr_q;
      end
      default: ;
    endcase
  end

  assign wr_beat    = write_master & ~waitrequest_master;
  assign rd_cmd_acc = read_master & ~waitrequest_master;
  assign wr_cnt_inc = wr_cnt_q + 1'b1;

  // A burst is tracked from its first presentation; a single stalled beat counts too
  assign wr_start = (state_q == StPass) & write_slave & ~wr_active_q &
                    ((burstcount_slave > BURSTCOUNT_WIDTH'(1)) | waitrequest_master);

  // Write tracker next state: count accepted beats, clear on the final one
  always_comb begin
    wr_active_d = wr_active_q;
    wr_len_d    = wr_len_q;
    wr_cnt_d    = wr_cnt_q;
    wr_addr_d   = wr_addr_q;
    if (wr_start) begin
      wr_active_d = 1'b1;
      wr_len_d    = burstcount_slave;
      wr_addr_d   = address_slave;
      wr_cnt_d    = {{(BURSTCOUNT_WIDTH - 1){1'b0}}, wr_beat};
    end else if (wr_active_q && wr_beat) begin
      if (wr_cnt_inc == wr_len_q) begin
        wr_active_d = 1'b0;
        wr_cnt_d    = '0;
      end else begin
        wr_cnt_d = wr_cnt_inc;
      end
    end
  end

`ifdef TERM_READ_DRAIN_EN
  // Pending read beats: add accepted burst length, subtract returned beats, saturate
  always_comb begin
    pend_add = SUM_W'(pend_q) + (rd_cmd_acc ? SUM_W'(burstcount_master) : '0);
    pend_dec = readdatavalid_master & (pend_add != '0);
    pend_sum = pend_add - SUM_W'(pend_dec);
    rd_ovf_d = rd_ovf_q;
    if (pend_sum > SUM_W'(MAX_RD_PENDING)) begin
      pend_d   = PEND_W'(MAX_RD_PENDING);
      rd_ovf_d = 1'b1;
    end else begin
      pend_d = PEND_W'(pend_sum);
    end
  end
`endif

  // Successor of a completed write drain or held read
  always_comb begin
`ifdef TERM_READ_DRAIN_EN
    drain_target = (pend_d != '0) ? StRdDrain : StLock;
`else
    drain_target = StLock;
`endif
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPass: begin
        if (rst_req_sync && init_seen_q) begin
          if (wr_active_d) begin
            state_d = StWrDrain;
          end else if (read_slave && waitrequest_master) begin
            state_d = StRdHold;
          end else begin
            state_d = drain_target;
          end
        end
      end
      StWrDrain: begin
        // Ignores the reset request: the burst must complete regardless
        if (!wr_active_d) state_d = drain_target;
      end
      StRdHold: begin
        if (!waitrequest_master) state_d = drain_target;
      end
`ifdef TERM_READ_DRAIN_EN
      StRdDrain: begin
        if (pend_d == '0) state_d = StLock;
      end
`endif
      StLock: begin
        if (!rst_req_sync) state_d = StPass;
      end
      default: state_d = StPass;
    endcase
  end

  // FSM state, power-up guard and registered status flags
  always_ff @(posedge clk) begin
    if (!rst_req_sync) init_seen_q <= 1'b1;
    state_q     <= state_d;
    quiesced_q  <= (state_d == StLock);
`ifdef TERM_READ_DRAIN_EN
    term_busy_q <= (state_d == StWrDrain) || (state_d == StRdHold) || (state_d == StRdDrain);
`else
    term_busy_q <= (state_d == StWrDrain) || (state_d == StRdHold);
`endif
  end

  // Tracker registers; the read command is captured whenever the user presents one
  always_ff @(posedge clk) begin
    wr_active_q <= wr_active_d;
    wr_len_q    <= wr_len_d;
    wr_cnt_q    <= wr_cnt_d;
    wr_addr_q   <= wr_addr_d;
    if ((state_q == StPass) && read_slave) begin
      rd_len_q  <= burstcount_slave;
      rd_addr_q <= address_slave;
    end
`ifdef TERM_READ_DRAIN_EN
    pend_q   <= pend_d;
    rd_ovf_q <= rd_ovf_d;
`endif
  end

  assign quiesced  = quiesced_q;
  assign term_busy = term_busy_q;

endmodule
